// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, sequencer states and helpers.
// Imported by the ALU control decoder and the execution-side sequencer.
package alu_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_XOR = 4'b0011,
    OP_SLL = 4'b0100,
    OP_SRL = 4'b0101,
    OP_SUB = 4'b0110,
    OP_SRA = 4'b0111,
    OP_EQ  = 4'b1000,
    OP_SLT = 4'b1100
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } alu_state_t;

  function automatic logic is_shift(alu_op_t op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle between the EX operand muxes and the ALU sequencer.
// master drives operations and result acceptance; slave is the ALU.
interface alu_seq_if #(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH_DEFAULT
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            op;
  logic [DATA_WIDTH-1:0] src_a;
  logic [DATA_WIDTH-1:0] src_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result;
  logic                  zero;
  logic                  busy;

  modport master (
    output in_valid, op, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, op, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/alu_comb.sv
// Single-cycle ALU ops (logic, add/sub, compare) and zero flag; purely combinational.
// Shift and unknown codes yield result 0 here; the sequencer owns shifts.
module alu_comb #(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH_DEFAULT
) (
  input  alu_pkg::alu_op_t       op,
  input  logic [DATA_WIDTH-1:0]  src_a,
  input  logic [DATA_WIDTH-1:0]  src_b,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   zero
);
  import alu_pkg::*;

  logic [DATA_WIDTH-1:0] diff;
  logic                  lt;

  assign diff = src_a - src_b;
  assign lt   = $signed(src_a) < $signed(src_b);

  always_comb begin
    result = '0;
    zero   = 1'b0;
    case (op)
      OP_AND:        result = src_a & src_b;
      OP_OR:         result = src_a | src_b;
      OP_ADD:        result = src_a + src_b;
      OP_XOR:        result = src_a ^ src_b;
      OP_SUB, OP_EQ: result = diff;
      OP_SLT:        result = {{(DATA_WIDTH-1){1'b0}}, lt};
      default:       result = '0;
    endcase
    // EQ flags operand equality directly rather than through the subtractor
    zero = (op == OP_EQ) ? (src_a == src_b) : (result == '0);
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU: latency 1 for single-cycle ops, shamt+1 for shifts (1 bit/cycle).
// One op in flight; in_ready only in IDLE, result held in DONE until out_ready.
module alu_seq #(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus
);
  import alu_pkg::*;

  localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

  alu_state_t             state_q,  state_d;
  alu_op_t                op_q,     op_d;
  logic [DATA_WIDTH-1:0]  work_q,   work_d;
  logic [SHAMT_WIDTH-1:0] cnt_q,    cnt_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic                   zero_q,   zero_d;

  alu_op_t                op_in;
  logic [SHAMT_WIDTH-1:0] shamt_in;
  logic [DATA_WIDTH-1:0]  comb_res;
  logic                   comb_zero;
  logic [DATA_WIDTH-1:0]  shifted;

  assign op_in    = alu_op_t'(bus.op);
  assign shamt_in = bus.src_b[SHAMT_WIDTH-1:0];

  alu_comb #(.DATA_WIDTH(DATA_WIDTH)) u_comb (
    .op     (op_in),
    .src_a  (bus.src_a),
    .src_b  (bus.src_b),
    .result (comb_res),
    .zero   (comb_zero)
  );

  always_comb begin
    case (op_q)
      OP_SLL:  shifted = {work_q[DATA_WIDTH-2:0], 1'b0};
      OP_SRA:  shifted = {work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
      default: shifted = {1'b0, work_q[DATA_WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          op_d = op_in;
          if (is_shift(op_in) && (shamt_in != '0)) begin
            work_d  = bus.src_a;
            cnt_d   = shamt_in;
            state_d = ST_SHIFT;
          end else if (is_shift(op_in)) begin
            result_d = bus.src_a;
            zero_d   = (bus.src_a == '0);
            state_d  = ST_DONE;
          end else begin
            result_d = comb_res;
            zero_d   = comb_zero;
            state_d  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - 1'b1;
        // the shift that empties the count lands straight in the output register
        if (cnt_q == SHAMT_WIDTH'(1)) begin
          result_d = shifted;
          zero_d   = (shifted == '0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_AND;
      work_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_SHIFT);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors, expected results queued at issue and
// checked by a monitor on each output handshake.
module tb_alu_seq;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    int          lat;
    int          busy;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  alu_seq_if #(.DATA_WIDTH(32)) bus ();

  alu_seq #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [32:0] exp_q[$];
  string       name_q[$];
  vec_t        vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic z,
                         input int lat, input int busy);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b;
    v.res = res; v.z = z; v.lat = lat; v.busy = busy;
    vecs.push_back(v);
  endtask

  // Issues one op once in_ready is seen, then measures latency and busy cycles.
  task automatic run_vec(input vec_t v);
    int waited;
    int lat;
    int nbusy;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) check({v.name, "_accept_timeout"}, 32'(waited), 32'd0);
    bus.op       = v.op;
    bus.src_a    = v.a;
    bus.src_b    = v.b;
    bus.in_valid = 1'b1;
    exp_q.push_back({v.res, v.z});
    name_q.push_back(v.name);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op       = 4'($urandom);
    bus.src_a    = $urandom;
    bus.src_b    = $urandom;
    lat   = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.busy) nbusy++;
    end while (!bus.out_valid && lat < 200);
    check({v.name, "_latency"}, 32'(lat), 32'(v.lat));
    check({v.name, "_busy_cycles"}, 32'(nbusy), 32'(v.busy));
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        string       nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check({nm, "_result"}, bus.result, e[32:1]);
        check({nm, "_zero"}, 32'(bus.zero), 32'(e[0]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ov_seen;
    vec_t v;

    bus.in_valid  = 1'b0;
    bus.op        = 4'd0;
    bus.src_a     = '0;
    bus.src_b     = '0;
    bus.out_ready = 1'b1;

    add_vec("add_wrap",   4'b0010, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1,  0);
    add_vec("sub_equal",  4'b0110, 32'h1234,      32'h1234,      32'h0,         1'b1, 1,  0);
    add_vec("eq_equal",   4'b1000, 32'h1234,      32'h1234,      32'h0,         1'b1, 1,  0);
    add_vec("eq_differ",  4'b1000, 32'h5,         32'h6,         32'hFFFF_FFFF, 1'b0, 1,  0);
    add_vec("slt_neg",    4'b1100, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1,  0);
    add_vec("slt_swap",   4'b1100, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b1, 1,  0);
    add_vec("sra_31",     4'b0111, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0, 32, 31);
    add_vec("srl_31",     4'b0101, 32'h8000_0000, 32'd31,        32'h0000_0001, 1'b0, 32, 31);
    add_vec("sra_shamt0", 4'b0111, 32'h8000_0000, 32'h20,        32'h8000_0000, 1'b0, 1,  0);
    add_vec("and",        4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1,  0);
    add_vec("or_zero",    4'b0001, 32'h0,         32'h0,         32'h0,         1'b1, 1,  0);
    add_vec("xor",        4'b0011, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 1'b0, 1,  0);
    add_vec("sll_4",      4'b0100, 32'h3,         32'd4,         32'h30,        1'b0, 5,  4);
    add_vec("bad_op",     4'b1010, 32'h1234_5678, 32'h9,         32'h0,         1'b1, 1,  0);
    add_vec("sll_1",      4'b0100, 32'h8000_0001, 32'd1,         32'h2,         1'b0, 2,  1);
    add_vec("sra_hi_b",   4'b0111, 32'h4000_0000, 32'h21,        32'h2000_0000, 1'b0, 2,  1);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result",    bus.result,         32'd0);
    check("rst_zero",      32'(bus.zero),      32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: result held in DONE, new requests ignored
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    v.name = "bp_add"; v.op = 4'b0010; v.a = 32'd3; v.b = 32'd4;
    v.res = 32'd7; v.z = 1'b0; v.lat = 1; v.busy = 0;
    run_vec(v);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.op       = 4'b0011;
      bus.src_a    = 32'hFF;
      bus.src_b    = 32'h0F;
      @(negedge clk);
      check("bp_result_hold", bus.result,         32'd7);
      check("bp_in_ready",    32'(bus.in_ready),  32'd0);
      check("bp_out_valid",   32'(bus.out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_in_ready",  32'(bus.in_ready),  32'd1);
    v.name = "bp_xor_after"; v.op = 4'b0011; v.a = 32'hFF; v.b = 32'h0F;
    v.res = 32'hF0; v.z = 1'b0; v.lat = 1; v.busy = 0;
    run_vec(v);

    // Reset mid-shift: SLL by 20 aborted around cycle 10
    @(negedge clk);
    bus.op       = 4'b0100;
    bus.src_a    = 32'h1;
    bus.src_b    = 32'd20;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("mid_shift_busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_result",    bus.result,         32'd0);
    check("abort_busy",      32'(bus.busy),      32'd0);
    check("abort_in_ready",  32'(bus.in_ready),  32'd1);
    ov_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid) ov_seen++;
    end
    check("abort_no_stale_valid", 32'(ov_seen), 32'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
